// File: rtl/rank_feeder.sv
// Block source for the rank sorter: streams DEPTH words per start, either from a
// write-loaded buffer (mode=0) or from an 8-bit Fibonacci LFSR (mode=1).
//
// state | meaning
// IDLE  | waiting for start; buffer writes accepted here
// LOAD  | fetching word 0 into out_data; ready rises on the edge leaving this state
// SEND  | offering words; one word moves per edge with valid & ready

module rank_feeder #(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 256,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              aclk,
    input  logic              aken,
    input  logic              start,
    input  logic              mode,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic              mode_q, mode_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        lfsr, lfsr_nxt, lfsr_step;
    logic [DATA_W-1:0] rd_word;
    logic              ready_nxt, busy_nxt, done_nxt;
    logic [DATA_W-1:0] out_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              start_acc, write_acc, xfer;

    assign start_acc = (state == IDLE) && start && !done;
    assign write_acc = (state == IDLE) && wr_en && !start_acc
                       && ({1'b0, wr_addr} < DEPTH_C);
    assign xfer      = (state == SEND) && valid && ready;

    // Address runs one word ahead in SEND so the registered read lands on the transfer edge.
    assign rd_addr   = (state == LOAD) ? rd_ptr : rd_ptr + 1'b1;
    assign rd_word   = mem[rd_addr];
    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        rd_ptr_nxt = rd_ptr;
        lfsr_nxt   = lfsr;
        ready_nxt  = ready;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        out_nxt    = out_data;
        count_nxt  = count;

        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_nxt  = LOAD;
                    mode_nxt   = mode;
                    rd_ptr_nxt = '0;
                    count_nxt  = '0;
                    lfsr_nxt   = LFSR_SEED;
                    busy_nxt   = 1'b1;
                end
            end
            LOAD: begin
                out_nxt   = mode_q ? DATA_W'(lfsr) : rd_word;
                ready_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (xfer) begin
                    count_nxt  = count + 1'b1;
                    rd_ptr_nxt = rd_ptr + 1'b1;
                    lfsr_nxt   = lfsr_step;
                    if (count == LAST_C) begin
                        ready_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        out_nxt = mode_q ? DATA_W'(lfsr_step) : rd_word;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aken) begin
        if (!aken) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            rd_ptr   <= '0;
            lfsr     <= LFSR_SEED;
            ready    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            rd_ptr   <= rd_ptr_nxt;
            lfsr     <= lfsr_nxt;
            ready    <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            out_data <= out_nxt;
            count    <= count_nxt;
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (write_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rank_feeder.sv
// Directed bench for rank_feeder: a scoreboard queue holds the expected word stream
// of each block and is checked every cycle ready is high.
module tb_rank_feeder;

    localparam int DEPTH = 256;

    logic       aclk = 1'b0;
    logic       aken;
    logic       start;
    logic       mode;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       valid;
    logic       ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [8:0] count;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int done_seen = 0;

    logic [7:0] q [$];
    logic [7:0] model_buf [DEPTH];

    rank_feeder #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(8), .LFSR_SEED(8'hA5)) dut (
        .aclk(aclk), .aken(aken), .start(start), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .valid(valid), .ready(ready), .out_data(out_data),
        .busy(busy), .done(done), .count(count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Offered word must equal the queue head on every ready cycle; pop on transfer.
    always @(negedge aclk) begin
        if (done === 1'b1) done_seen++;
        if (aken === 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                check("sb_empty", 32'(q.size()), 32'd1);
            end else begin
                check("data", 32'(out_data), 32'(q[0]));
                if (valid === 1'b1) begin
                    void'(q.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic push_block(input bit m);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < DEPTH; i++) begin
            if (m) begin
                q.push_back(l);
                l = lfsr_nx(l);
            end else begin
                q.push_back(model_buf[i]);
            end
        end
    endtask

    task automatic run_block(input bit m, input bit rnd, input bit disturb,
                             input int abort_at, input bit wr_with_start);
        int  base;
        int  c;
        bit  aborted;
        push_block(m);
        base    = done_seen;
        xfers   = 0;
        aborted = 0;
        mode    = m;
        start   = 1'b1;
        valid   = 1'b1;
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_addr = 8'd5;
            wr_data = 8'h11;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("lat1_busy", 32'(busy), 32'd1);
        check("lat1_ready", 32'(ready), 32'd0);
        tick();
        check("lat2_ready", 32'(ready), 32'd1);
        c = 0;
        while (done !== 1'b1 && c < 3000 && !aborted) begin
            valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (disturb && c == 10) begin
                wr_en   = 1'b1;
                wr_addr = 8'd3;
                wr_data = 8'h77;
                start   = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (abort_at != 0 && xfers == abort_at) begin
                check("cnt_pre_abort", 32'(count), 32'(abort_at));
                aken = 1'b0;
                #1;
                check("abort_ready", 32'(ready), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_count", 32'(count), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                q.delete();
                tick();
                aken = 1'b1;
                tick();
                tick();
                check("abort_no_done", 32'(done_seen - base), 32'd0);
                aborted = 1;
            end else begin
                tick();
                c++;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check("done_timeout", 32'(done), 32'd1);
            check("final_count", 32'(count), 32'(DEPTH));
            check("final_busy", 32'(busy), 32'd0);
            check("final_ready", 32'(ready), 32'd0);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_on_done", 32'(busy), 32'd0);
            tick();
            check("done_pulses", 32'(done_seen - base), 32'd1);
            check("sb_drained", 32'(q.size()), 32'd0);
        end
    endtask

    initial begin
        aken    = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        valid   = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        aken = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = 8'(255 - i);
            model_buf[i] = 8'(255 - i);
            tick();
        end
        wr_en = 1'b0;
        tick();

        run_block(1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_block(1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_block(1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_block(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_block(1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_block(1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_block(1'b0, 1'b0, 1'b0, 100, 1'b0);

        valid = 1'b1;
        repeat (4) tick();
        check("idle_valid_count", 32'(count), 32'd0);
        check("idle_valid_ready", 32'(ready), 32'd0);

        run_block(1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_block(1'b0, 1'b1, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
